rom_loader: RTL and testbench

- Byte-stream writer that fills the SoC instruction ROM at runtime, in place of the simulation-only hex preload.
- Sits between a byte source (UART RX or bench driver) and the ROM write port.
- Holds the CPU in reset while loading and releases it only after a complete, checksum-verified image.
- Also reports done/error status that the bench can poll alongside the x26/x27 pass/fail convention.

---
 rtl/rom_loader_if.sv | 55 +++++
 rtl/rom_loader.sv | 205 ++++++++++++++++++++
 tb/tb_rom_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// rom_loader_if
// Bundles the byte-stream input, the ROM write port and the load status
// of the ROM loader into one bundle.
//
// Signals:
//   rx_data    [7:0]             incoming byte
//   rx_valid                     rx_data valid
//   rx_ready                     loader accepts the byte (always 1)
//   rom_we                       one-cycle ROM word write strobe
//   rom_waddr  [ADDR_WIDTH-1:0]  ROM word address
//   rom_wdata  [31:0]            ROM word data
//   cpu_hold                     1 = keep the CPU in reset
//   done                         image loaded and checksum verified
//   err                          frame error (length, checksum, timeout)
//
// Modports:
//   master - the loader: consumes bytes, drives the ROM port and status
//   slave  - the byte source / ROM / SoC side
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  rom_we;
  logic [ADDR_WIDTH-1:0] rom_waddr;
  logic [31:0]           rom_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  err;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output rom_we,
    output rom_waddr,
    output rom_wdata,
    output cpu_hold,
    output done,
    output err
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  rom_we,
    input  rom_waddr,
    input  rom_wdata,
    input  cpu_hold,
    input  done,
    input  err
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader
// Fills the SoC instruction ROM from a byte stream at runtime. The frame is
//   MAGIC, LEN_LO, LEN_HI, N x 4 data bytes (little-endian words), CSUM
// where N is the 16-bit word count and CSUM is the XOR of all data bytes.
// The CPU is held in reset until a complete frame with a matching checksum
// has been received. Bytes are never stalled, so rx_ready is constant 1.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - rom_loader_if.master: byte input, ROM write port, status outputs
//
// Parameters:
//   ADDR_WIDTH  - ROM word-address width (depth 2**ADDR_WIDTH words)
//   MAGIC       - frame start byte
//   TIMEOUT_CYC - max idle clocks between bytes inside a frame
module rom_loader #(
  parameter int         ADDR_WIDTH  = 12,
  parameter logic [7:0] MAGIC       = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input logic          clk,
  input logic          rst,
  rom_loader_if.master bus
);

  // Idle counter is wide enough to hold TIMEOUT_CYC-1; the abort fires on
  // the idle edge that would bring it to TIMEOUT_CYC.
  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state;
  logic [7:0]            len_lo;
  logic [ADDR_WIDTH-1:0] last_word;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           word_asm;
  logic [7:0]            csum;
  logic [TW-1:0]         idle_cnt;

  logic                  rom_we_q;
  logic [ADDR_WIDTH-1:0] rom_waddr_q;
  logic [31:0]           rom_wdata_q;
  logic                  cpu_hold_q;
  logic                  done_q;
  logic                  err_q;

  logic [16:0]           n_words;
  logic [ADDR_WIDTH-1:0] last_from_n;
  logic                  in_frame;

  // Word count as it completes on the LEN_HI byte. One extra bit lets the
  // oversize test see N == 2**ADDR_WIDTH without wrapping. Once N is known
  // to be in range, N-1 always fits in ADDR_WIDTH bits.
  assign n_words     = {1'b0, bus.rx_data, len_lo};
  assign last_from_n = ADDR_WIDTH'(n_words - 17'd1);

  // Only the states that sit in the middle of a frame can time out.
  assign in_frame = (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA) || (state == S_CSUM);

  assign bus.rx_ready  = 1'b1;
  assign bus.rom_we    = rom_we_q;
  assign bus.rom_waddr = rom_waddr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Frame parser. Each accepted byte advances the state machine. Bytes in
  // DATA are shifted into the top of a 24-bit assembly register, so after
  // three bytes it holds {b2,b1,b0}. The fourth byte completes the word,
  // and the write is registered so rom_we appears the cycle after that
  // byte. When no byte arrives inside a frame, the idle counter advances
  // and eventually aborts to ERR. Writes that were already issued stay in
  // the ROM, and cpu_hold remains set so the partial image never runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      len_lo      <= '0;
      last_word   <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      word_asm    <= '0;
      csum        <= '0;
      idle_cnt    <= '0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rom_we_q <= 1'b0;
      if (in_frame && !bus.rx_valid) begin
        if (idle_cnt == IDLE_LAST) begin
          state      <= S_ERR;
          err_q      <= 1'b1;
          cpu_hold_q <= 1'b1;
          done_q     <= 1'b0;
          idle_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else if (bus.rx_valid) begin
        idle_cnt <= '0;
        unique case (state)
          S_IDLE: begin
            if (bus.rx_data == MAGIC) begin
              state <= S_LEN0;
            end
          end

          S_LEN0: begin
            len_lo <= bus.rx_data;
            state  <= S_LEN1;
          end

          S_LEN1: begin
            word_idx  <= '0;
            byte_idx  <= '0;
            word_asm  <= '0;
            csum      <= '0;
            last_word <= last_from_n;
            if (n_words > MAX_WORDS) begin
              state      <= S_ERR;
              err_q      <= 1'b1;
              cpu_hold_q <= 1'b1;
              done_q     <= 1'b0;
            end else if (n_words == 17'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end

          S_DATA: begin
            word_asm <= {bus.rx_data, word_asm[23:8]};
            csum     <= csum ^ bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              rom_we_q    <= 1'b1;
              rom_waddr_q <= word_idx;
              rom_wdata_q <= {bus.rx_data, word_asm};
              // After the final word the index is left as-is: it would wrap
              // for a full-depth image, but it is cleared again on the next
              // frame before any further use.
              word_idx    <= word_idx + 1'b1;
              if (word_idx == last_word) begin
                state <= S_CSUM;
              end
            end
          end

          S_CSUM: begin
            if (bus.rx_data == csum) begin
              state      <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              err_q      <= 1'b0;
            end else begin
              state      <= S_ERR;
              err_q      <= 1'b1;
              cpu_hold_q <= 1'b1;
              done_q     <= 1'b0;
            end
          end

          S_DONE: begin
            // A new frame puts the CPU back into reset immediately, before
            // any of the old image is overwritten.
            if (bus.rx_data == MAGIC) begin
              state      <= S_LEN0;
              done_q     <= 1'b0;
              cpu_hold_q <= 1'b1;
            end
          end

          S_ERR: begin
            if (bus.rx_data == MAGIC) begin
              state <= S_LEN0;
              err_q <= 1'b0;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
// Self-checking bench for rom_loader with ADDR_WIDTH=4 and TIMEOUT_CYC=50.
// The stimulus tasks queue frame bytes, and they push each expected ROM
// write onto a scoreboard. The write records the position of the byte that
// completes the word. A monitor on the falling edge pops one entry for every
// rom_we pulse. It checks address, data and the one-cycle latency against
// the acceptance cycle of that byte. Status outputs are checked directly
// after the relevant byte.
module tb_rom_loader;

  localparam int AW = 4;
  localparam int TO = 50;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            pos;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  rom_loader_if #(.ADDR_WIDTH(AW)) bus ();

  rom_loader #(
    .ADDR_WIDTH (AW),
    .MAGIC      (8'hA5),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad   = 0;
  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         acc_cyc[256];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected
  // write and must appear in the cycle after its completing byte.
  always @(negedge clk) begin
    wr_t e;
    if (bus.rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                 bus.rom_waddr, bus.rom_wdata);
      end else begin
        e = exp_q.pop_front();
        check_output("write_addr", 32'(bus.rom_waddr), 32'(e.addr));
        check_output("write_data", bus.rom_wdata, e.data);
        check_output("write_latency", cyc, acc_cyc[e.pos]);
      end
    end
  end

  task automatic add_byte(input logic [7:0] b);
    tx_q.push_back(b);
  endtask

  // Expects a write completed by the most recently queued byte.
  task automatic expect_write(input logic [AW-1:0] addr, input logic [31:0] data);
    exp_q.push_back('{addr, data, tx_q.size() - 1});
  endtask

  task automatic add_word(input logic [AW-1:0] addr, input logic [31:0] w);
    add_byte(w[7:0]);
    add_byte(w[15:8]);
    add_byte(w[23:16]);
    add_byte(w[31:24]);
    expect_write(addr, w);
  endtask

  // Sends the queued bytes, with up to gap_max idle cycles before each one.
  task automatic apply_stimulus(input int gap_max);
    for (int i = 0; i < tx_q.size(); i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        bus.rx_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      bus.rx_data  = tx_q[i];
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc[i] = cyc;
    end
    bus.rx_valid = 1'b0;
    tx_q.delete();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic h);
    check_output({tag, "_done"}, 32'(bus.done), 32'(d));
    check_output({tag, "_err"}, 32'(bus.err), 32'(e));
    check_output({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(h));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    check_output({tag, "_rom_we"}, 32'(bus.rom_we), 32'd0);
    check_output({tag, "_rom_waddr"}, 32'(bus.rom_waddr), 32'd0);
    check_output({tag, "_rom_wdata"}, bus.rom_wdata, 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    int          waited;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal two-word image, back-to-back.
    // CSUM = 13^00^00^00^93^00^10^00 = 90
    add_byte(8'hA5); add_byte(8'h02); add_byte(8'h00);
    add_byte(8'h13); add_byte(8'h00); add_byte(8'h00); add_byte(8'h00);
    expect_write(0, 32'h0000_0013);
    add_byte(8'h93); add_byte(8'h00); add_byte(8'h10); add_byte(8'h00);
    expect_write(1, 32'h0010_0093);
    add_byte(8'h90);
    apply_stimulus(0);
    check_status("nominal", 1'b1, 1'b0, 1'b0);
    check_output("nominal_writes_left", exp_q.size(), 32'd0);

    // Same image with a wrong checksum: words still written, then error.
    add_byte(8'hA5); add_byte(8'h02); add_byte(8'h00);
    add_byte(8'h13); add_byte(8'h00); add_byte(8'h00); add_byte(8'h00);
    expect_write(0, 32'h0000_0013);
    add_byte(8'h93); add_byte(8'h00); add_byte(8'h10); add_byte(8'h00);
    expect_write(1, 32'h0010_0093);
    add_byte(8'h81);
    apply_stimulus(0);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1);
    check_output("bad_csum_writes_left", exp_q.size(), 32'd0);

    // N = 17 exceeds 16-word ROM: error right after LEN_HI.
    add_byte(8'hA5); add_byte(8'h11); add_byte(8'h00);
    apply_stimulus(0);
    check_status("oversize", 1'b0, 1'b1, 1'b1);

    // Recovery from error with a one-word image. CSUM = DE^AD^BE^EF = 22
    add_byte(8'hA5); add_byte(8'h01); add_byte(8'h00);
    add_byte(8'hDE); add_byte(8'hAD); add_byte(8'hBE); add_byte(8'hEF);
    expect_write(0, 32'hEFBE_ADDE);
    add_byte(8'h22);
    apply_stimulus(0);
    check_status("recover", 1'b1, 1'b0, 1'b0);
    check_output("recover_writes_left", exp_q.size(), 32'd0);

    // Timeout: the error must rise exactly TO cycles after the last byte.
    add_byte(8'hA5); add_byte(8'h01); add_byte(8'h00); add_byte(8'h11);
    apply_stimulus(0);
    waited = 0;
    while (bus.err !== 1'b1 && waited < 4 * TO) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_output("timeout_cycles", waited, TO);
    check_status("timeout", 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a frame, after two data bytes.
    add_byte(8'hA5); add_byte(8'h02); add_byte(8'h00);
    add_byte(8'h11); add_byte(8'h22);
    apply_stimulus(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("mid_reset");
    rst = 1'b0;

    // Zero-length image: checksum of no bytes is 00.
    add_byte(8'hA5); add_byte(8'h00); add_byte(8'h00); add_byte(8'h00);
    apply_stimulus(0);
    check_status("zero_len", 1'b1, 1'b0, 1'b0);

    // Full-depth image: N = 16 writes every address exactly once.
    cs = 8'h00;
    add_byte(8'hA5); add_byte(8'h10); add_byte(8'h00);
    for (int i = 0; i < 16; i++) begin
      w = 32'h1000_0001 + 32'(i) * 32'h0102_0304;
      add_word(AW'(i), w);
      cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    add_byte(cs);
    apply_stimulus(0);
    check_status("full_depth", 1'b1, 1'b0, 1'b0);
    check_output("full_depth_writes_left", exp_q.size(), 32'd0);

    // Reload from DONE with gapped bytes: MAGIC alone re-holds the CPU.
    add_byte(8'hA5);
    apply_stimulus(3);
    check_status("reload_magic", 1'b0, 1'b0, 1'b1);
    // CSUM = BE^BA^FE^CA^78^56^34^12 = 38
    add_byte(8'h02); add_byte(8'h00);
    add_byte(8'hBE); add_byte(8'hBA); add_byte(8'hFE); add_byte(8'hCA);
    expect_write(0, 32'hCAFE_BABE);
    add_byte(8'h78); add_byte(8'h56); add_byte(8'h34); add_byte(8'h12);
    expect_write(1, 32'h1234_5678);
    add_byte(8'h38);
    apply_stimulus(6);
    check_status("reload", 1'b1, 1'b0, 1'b0);
    check_output("reload_writes_left", exp_q.size(), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
